// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
// Operation-select encodings used by the mode port.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

endpackage

// File: rtl/dff_bank.sv
// WIDTH-wide D register with synchronous reset value and enable.
// Holds the shift register contents for univ_shift_reg.
module dff_bank #(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load,
// with a saturating shift counter and a one-cycle done pulse.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             so_r,
    output logic             so_l,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             done_q;
    logic             done_d;
    logic             shifting;

    generate
        if (WIDTH == 1) begin : g_w1
            assign shr_val = sin_r;
            assign shl_val = sin_l;
        end else begin : g_wn
            assign shr_val = {sin_r, q[WIDTH-1:1]};
            assign shl_val = {q[WIDTH-2:0], sin_l};
        end
    endgenerate

    always_comb begin
        q_d      = q;
        shifting = 1'b0;
        unique case (mode_e'(mode))
            MODE_SHR: begin
                q_d      = shr_val;
                shifting = 1'b1;
            end
            MODE_SHL: begin
                q_d      = shl_val;
                shifting = 1'b1;
            end
            MODE_LOAD: q_d = d;
            default:   q_d = q;
        endcase
    end

    // Counting is direction-agnostic; saturation stops further done pulses.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            if (mode_e'(mode) == MODE_LOAD) begin
                cnt_d = '0;
            end else if (shifting && cnt_q != CNT_MAX) begin
                cnt_d  = cnt_q + 1'b1;
                done_d = (cnt_q == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    dff_bank #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
    ) u_bank (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (q_d),
        .q   (q)
    );

    assign qb   = ~q;
    assign so_r = q[0];
    assign so_l = q[WIDTH-1];
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8 and WIDTH=1 instances).
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst, en, sin_r, sin_l;
    logic [1:0] mode;
    logic [7:0] d, q, qb;
    logic       so_r, so_l, done;

    logic       rst1, en1, sin_r1, sin_l1;
    logic [1:0] mode1;
    logic [0:0] d1, q1, qb1;
    logic       so_r1, so_l1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q), .qb(qb),
        .so_r(so_r), .so_l(so_l), .done(done)
    );

    univ_shift_reg #(.WIDTH(1), .RST_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .d(d1),
        .sin_r(sin_r1), .sin_l(sin_l1), .q(q1), .qb(qb1),
        .so_r(so_r1), .so_l(so_l1), .done(done1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 1; mode = 2'b11; d = 8'hFF;
        sin_r = 0; sin_l = 0;
        rst1 = 1; en1 = 1; mode1 = 2'b00; d1 = 1'b0;
        sin_r1 = 0; sin_l1 = 0;
        step();
        step();
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL reset_q: got %h want 00", q);
        end
        checks++;
        if (qb !== 8'hFF) begin
            errors++;
            $display("FAIL reset_qb: got %h want ff", qb);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b want 0", done);
        end
        rst = 0;
    endtask

    task automatic test_shift_right();
        logic [7:0] pat;
        pat = 8'hA5;
        en = 1; mode = 2'b11; d = pat;
        step();
        checks++;
        if (q !== 8'hA5) begin
            errors++;
            $display("FAIL shr_load: got %h want a5", q);
        end
        mode = 2'b01; sin_r = 0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (so_r !== pat[i]) begin
                errors++;
                $display("FAIL shr_so_r[%0d]: got %b want %b", i, so_r, pat[i]);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL shr_done_early[%0d]: got %b want 0", i, done);
            end
            step();
        end
        checks++;
        if (q !== 8'h00) begin
            errors++;
            $display("FAIL shr_final_q: got %h want 00", q);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL shr_done: got %b want 1", done);
        end
        mode = 2'b00;
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL shr_done_pulse: got %b want 0", done);
        end
    endtask

    task automatic test_shift_left_hold();
        en = 1; mode = 2'b11; d = 8'h81;
        step();
        mode = 2'b10; sin_l = 1;
        step();
        checks++;
        if (q !== 8'h03) begin
            errors++;
            $display("FAIL shl_q: got %h want 03", q);
        end
        checks++;
        if (so_l !== 1'b0) begin
            errors++;
            $display("FAIL shl_so_l: got %b want 0", so_l);
        end
        en = 0; d = 8'hFF; sin_r = 1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (q !== 8'h03 || qb !== 8'hFC) begin
            errors++;
            $display("FAIL en0_hold: got q=%h qb=%h want 03/fc", q, qb);
        end
        en = 1; mode = 2'b00; d = 8'h55;
        step();
        step();
        checks++;
        if (q !== 8'h03 || done !== 1'b0) begin
            errors++;
            $display("FAIL mode00_hold: got q=%h done=%b want 03/0", q, done);
        end
        sin_l = 0; sin_r = 0;
    endtask

    task automatic test_reset_abort();
        en = 1; mode = 2'b11; d = 8'hFF;
        step();
        mode = 2'b01; sin_r = 0;
        for (int i = 0; i < 5; i++) step();
        rst = 1;
        step();
        rst = 0;
        checks++;
        if (q !== 8'h00 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst: got q=%h done=%b want 00/0", q, done);
        end
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++;
            if (q !== 8'h00 || done !== (i == 8)) begin
                errors++;
                $display("FAIL abort_shift[%0d]: got q=%h done=%b want 00/%b",
                         i, q, done, (i == 8));
            end
        end
    endtask

    task automatic test_reload();
        int ndone;
        en = 1; mode = 2'b11; d = 8'hFF;
        step();
        mode = 2'b01; sin_r = 0; sin_l = 0;
        for (int i = 0; i < 4; i++) step();
        mode = 2'b11; d = 8'h3C;
        step();
        ndone = 0;
        for (int i = 1; i <= 10; i++) begin
            mode = (i % 2 == 1) ? 2'b01 : 2'b10;
            step();
            if (done === 1'b1) ndone++;
            checks++;
            if (done !== (i == 8)) begin
                errors++;
                $display("FAIL reload_done[%0d]: got %b want %b", i, done, (i == 8));
            end
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL reload_done_count: got %0d want 1", ndone);
        end
        checks++;
        if (q !== 8'h3C) begin
            errors++;
            $display("FAIL reload_mixed_q: got %h want 3c", q);
        end
    endtask

    task automatic test_width1();
        checks++;
        if (q1 !== 1'b1 || qb1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_reset: got q=%b qb=%b done=%b want 1/0/0",
                     q1, qb1, done1);
        end
        rst1 = 0; en1 = 1; mode1 = 2'b01; sin_r1 = 0;
        step();
        checks++;
        if (q1 !== 1'b0 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL w1_shr: got q=%b done=%b want 0/1", q1, done1);
        end
        mode1 = 2'b10; sin_l1 = 1;
        step();
        checks++;
        if (q1 !== 1'b1 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_shl_sat: got q=%b done=%b want 1/0", q1, done1);
        end
    endtask

    initial begin
        test_reset();
        test_shift_right();
        test_shift_left_hold();
        test_reset_abort();
        test_reload();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
